// File: rtl/seq_det_pkg.sv
// Shared types for the parameterised serial pattern detector.
// Holds the one-hot detector state encoding.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNLOADED = 2'b01,
    ARMED    = 2'b10
  } det_state_e;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clock, reset (async high), inc, clear, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern/length.
// Ports: clock, reset, a, in_valid, pat_load, pat_value, pat_len,
//   overlap, count_clear -> found_it, match_count, armed, load_err.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8,
  parameter int LENW   = $clog2(MAXLEN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a,
  input  logic              in_valid,
  input  logic              pat_load,
  input  logic [MAXLEN-1:0] pat_value,
  input  logic [LENW-1:0]   pat_len,
  input  logic              overlap,
  input  logic              count_clear,
  output logic              found_it,
  output logic [CNTW-1:0]   match_count,
  output logic              armed,
  output logic              load_err
);

  det_state_e        state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   fill_q, fill_d;
  logic              err_q, err_d;

  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic              accept;
  logic              hit;
  logic              fill_ok;
  logic              len_ok;
  logic [LENW-1:0]   fill_inc;

  // Candidate window: stored history with the current bit appended.
  assign window = {hist_q[MAXLEN-2:0], a};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++)
      mask[i] = (32'(i) < 32'(len_q));
  end

  assign hit    = ((window ^ pat_q) & mask) == '0;
  // fill + 1 >= len, i.e. this sample completes a full window.
  assign fill_ok = ((LENW+1)'(fill_q) + (LENW+1)'(1))
                   >= (LENW+1)'(len_q);
  assign accept  = in_valid & (state_q == ARMED) & ~pat_load;
  assign found_it = accept & fill_ok & hit;

  assign len_ok = (pat_len != '0) &&
                  (pat_len <= LENW'(MAXLEN));
  assign fill_inc = (fill_q < len_q) ? fill_q + LENW'(1)
                                     : fill_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    len_d   = len_q;
    fill_d  = fill_q;
    err_d   = err_q;
    if (pat_load) begin
      if (len_ok) begin
        state_d = ARMED;
        pat_d   = pat_value;
        len_d   = pat_len;
        hist_d  = '0;
        fill_d  = '0;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (accept) begin
      hist_d = window;
      // Non-overlapping mode restarts the window after a hit.
      if (found_it && !overlap) fill_d = '0;
      else                      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= UNLOADED;
      pat_q   <= '0;
      hist_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  assign armed    = (state_q == ARMED);
  assign load_err = err_q;

  sat_counter #(.W(CNTW)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (found_it),
    .clear (count_clear),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (MAXLEN=8, CNTW=2).
// Expected flag/count per sample are queued at drive time.
module tb_seq_detector_param;

  localparam int MAXLEN = 8;
  localparam int CNTW   = 2;
  localparam int LENW   = $clog2(MAXLEN + 1);

  logic              clock = 0;
  logic              reset = 0;
  logic              a = 0;
  logic              in_valid = 0;
  logic              pat_load = 0;
  logic [MAXLEN-1:0] pat_value = '0;
  logic [LENW-1:0]   pat_len = '0;
  logic              overlap = 1;
  logic              count_clear = 0;
  logic              found_it;
  logic [CNTW-1:0]   match_count;
  logic              armed;
  logic              load_err;

  seq_detector_param #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clock       (clock),
    .reset       (reset),
    .a           (a),
    .in_valid    (in_valid),
    .pat_load    (pat_load),
    .pat_value   (pat_value),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .count_clear (count_clear),
    .found_it    (found_it),
    .match_count (match_count),
    .armed       (armed),
    .load_err    (load_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    logic  f;
    int    c;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic samp(input logic b, input logic ef,
                      input int ec, input string tag);
    exp_t e;
    @(negedge clock);
    in_valid = 1;
    a = b;
    q.push_back('{tag, ef, ec});
    #1;
    e = q.pop_front();
    chk({e.tag, "_found"}, 32'(found_it), 32'(e.f));
    @(posedge clock);
    #1;
    chk({e.tag, "_cnt"}, 32'(match_count), 32'(e.c));
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 0;
      a = 1;
      #1;
      chk("idle_found", 32'(found_it), 32'd0);
    end
  endtask

  task automatic load(input logic [MAXLEN-1:0] pv,
                      input logic [LENW-1:0] pl,
                      input logic with_sample,
                      input string tag);
    @(negedge clock);
    pat_load = 1;
    pat_value = pv;
    pat_len = pl;
    in_valid = with_sample;
    a = 1;
    #1;
    chk({tag, "_ld_found"}, 32'(found_it), 32'd0);
    @(posedge clock);
    #1;
    pat_load = 0;
    in_valid = 0;
  endtask

  task automatic clr(input string tag);
    @(negedge clock);
    count_clear = 1;
    @(posedge clock);
    #1;
    count_clear = 0;
    chk({tag, "_clr"}, 32'(match_count), 32'd0);
  endtask

  initial begin
    // reset state
    reset = 1;
    #12;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_found", 32'(found_it), 32'd0);
    reset = 0;

    // unloaded ignores samples
    samp(1, 0, 0, "unl0");

    // 101 overlapping
    overlap = 1;
    load(8'b101, 4'd3, 0, "ov");
    chk("ov_armed", 32'(armed), 32'd1);
    samp(1, 0, 0, "ov1");
    samp(0, 0, 0, "ov2");
    samp(1, 1, 1, "ov3");
    samp(0, 0, 1, "ov4");
    samp(1, 1, 2, "ov5");
    clr("ov");

    // 101 non-overlapping
    overlap = 0;
    load(8'b101, 4'd3, 0, "no");
    samp(1, 0, 0, "no1");
    samp(0, 0, 0, "no2");
    samp(1, 1, 1, "no3");
    samp(0, 0, 1, "no4");
    samp(1, 0, 1, "no5");
    samp(0, 0, 1, "no6");
    samp(1, 1, 2, "no7");
    clr("no");

    // A5 length 8 with gaps
    overlap = 1;
    load(8'hA5, 4'd8, 0, "a5");
    samp(1, 0, 0, "a5_1");
    idle(2);
    samp(0, 0, 0, "a5_2");
    samp(1, 0, 0, "a5_3");
    idle(1);
    samp(0, 0, 0, "a5_4");
    samp(0, 0, 0, "a5_5");
    idle(3);
    samp(1, 0, 0, "a5_6");
    samp(0, 0, 0, "a5_7");
    samp(1, 1, 1, "a5_8");
    clr("a5");

    // length 1, saturation at 3
    load(8'b1, 4'd1, 0, "l1");
    samp(1, 1, 1, "l1_1");
    samp(1, 1, 2, "l1_2");
    samp(1, 1, 3, "l1_3");
    samp(1, 1, 3, "l1_4");
    samp(1, 1, 3, "l1_5");
    samp(0, 0, 3, "l1_0");
    @(negedge clock);
    count_clear = 1;
    in_valid = 1;
    a = 1;
    q.push_back('{"clrhit", 1'b1, 0});
    begin
      exp_t e;
      #1;
      e = q.pop_front();
      chk({e.tag, "_found"}, 32'(found_it), 32'(e.f));
      @(posedge clock);
      #1;
      chk({e.tag, "_cnt"}, 32'(match_count), 32'(e.c));
    end
    count_clear = 0;
    in_valid = 0;

    // bad loads keep previous pattern
    load(8'hFF, 4'd0, 0, "bad0");
    chk("bad0_err", 32'(load_err), 32'd1);
    chk("bad0_armed", 32'(armed), 32'd1);
    samp(1, 1, 1, "bad0_keep");
    load(8'hFF, 4'd9, 0, "bad9");
    chk("bad9_err", 32'(load_err), 32'd1);
    chk("bad9_armed", 32'(armed), 32'd1);
    load(8'b101, 4'd3, 0, "good");
    chk("good_err", 32'(load_err), 32'd0);
    chk("good_armed", 32'(armed), 32'd1);

    // reset mid-stream
    samp(1, 0, 1, "mr1");
    samp(0, 0, 1, "mr2");
    @(negedge clock);
    reset = 1;
    #2;
    chk("mr_armed", 32'(armed), 32'd0);
    chk("mr_cnt", 32'(match_count), 32'd0);
    reset = 0;
    samp(1, 0, 0, "mr_unl");
    load(8'b101, 4'd3, 0, "mr");
    samp(1, 0, 0, "mr3");

    // load with concurrent sample
    samp(0, 0, 0, "ls1");
    load(8'b101, 4'd3, 1, "ls");
    samp(1, 0, 0, "ls2");
    samp(0, 0, 0, "ls3");
    samp(1, 1, 1, "ls4");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
